// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   - uart_state_e : frame sequencing states (IDLE, START, DATA, PARITY, STOP)
//   - LINE_*       : serial line levels for idle, start and stop
//   - *_DEF        : default frame geometry (8 data bits, 115200 baud @ 50 MHz)
//   - frame_clks() : total clk cycles occupied by one frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Line levels: the line idles high, a frame opens with a low start bit.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam int UART_DATA_W_DEF       = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 434;
  localparam int UART_STOP_BITS_DEF    = 1;

  // Cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_clks(input int data_w, input int parity_en,
                                    input int stop_bits, input int clks_per_bit);
    return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while run is high and pulses tick
// on the last cycle of every bit period. Held at 0 while run is low, so a new
// frame always starts with a full-length first bit.
// Ports:
//   clk     : system clock, posedge
//   reset_n : asynchronous active-low reset
//   run     : count enable; counter cleared while low
//   tick    : one-cycle pulse on the final cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignment so each one samples the values
  // that were present before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// UART serializer fed by a valid/ready byte stream. Each accepted word is sent
// as: 1 start bit, DATA_W data bits LSB-first, optional parity bit, STOP_BITS
// stop bits. txd comes straight from a flop, one cycle behind the state, so
// it falls on the first posedge after the handshake edge.
// s_ready is high in IDLE and in the final cycle of the last stop bit; a
// handshake in that cycle chains the next frame with no idle gap.
// Ports:
//   clk     : system clock, posedge
//   reset_n : asynchronous active-low reset; aborts any frame in flight
//   s_valid : upstream word valid
//   s_ready : a word is accepted this cycle if s_valid is also high
//   s_data  : word to transmit, captured at the handshake edge
//   txd     : serial line, idle high
//   busy    : a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W_DEF,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = UART_STOP_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              txd,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] LAST_STOP_BIT = BCW'(STOP_BITS - 1);
  localparam logic           PAR_ODD       = (PARITY_ODD != 0);
  localparam uart_state_e    AFTER_DATA    = (PARITY_EN != 0) ? S_PARITY : S_STOP;

  uart_state_e       state_q, state_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              txd_q, txd_d;

  logic tick;
  logic baud_run;
  logic last_stop_cycle;
  logic handshake;

  assign baud_run = (state_q != S_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (baud_run),
    .tick   (tick)
  );

  // s_ready depends only on registered state and the counters.
  assign last_stop_cycle = (state_q == S_STOP) && tick && (bit_q == LAST_STOP_BIT);
  assign s_ready         = (state_q == S_IDLE) || last_stop_cycle;
  assign handshake       = s_valid && s_ready;

  assign txd  = txd_q;
  assign busy = (state_q != S_IDLE);

  // Next-state, counters and capture.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d  = S_START;
          shift_d  = s_data;
          parity_d = (^s_data) ^ PAR_ODD;
        end
      end

      S_START: begin
        if (tick) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA_BIT) begin
            bit_d   = '0;
            state_d = AFTER_DATA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP_BIT) begin
            bit_d = '0;
            // Chaining straight into START keeps frames gap-free.
            if (handshake) begin
              state_d  = S_START;
              shift_d  = s_data;
              parity_d = (^s_data) ^ PAR_ODD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered so txd never glitches.
  always_comb begin
    txd_d = LINE_IDLE;
    unique case (state_q)
      S_IDLE:   txd_d = LINE_IDLE;
      S_START:  txd_d = LINE_START;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = parity_q;
      S_STOP:   txd_d = LINE_STOP;
      default:  txd_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= LINE_IDLE;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
// Four transmitters with CLKS_PER_BIT=4, DATA_W=8:
//   0: no parity, 1 stop   1: even parity, 1 stop
//   2: odd parity, 1 stop  3: no parity, 2 stops
// The stimulus side pushes {word, handshake cycle} into a per-instance queue;
// the monitor detects each start bit on txd, pops, and compares the line cycle
// by cycle with levels computed from the frame rules. s_ready/busy are traced
// against the handshake history.
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

  localparam int C  = 4;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int PE_P [N] = '{0, 1, 1, 0};
  localparam int PO_P [N] = '{0, 0, 1, 0};
  localparam int SB_P [N] = '{1, 1, 1, 2};

  typedef struct {
    logic [7:0] data;
    int         hs;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  s_valid;
  logic [DW-1:0] s_data [N];
  wire  [N-1:0]  s_ready;
  wire  [N-1:0]  txd_w;
  wire  [N-1:0]  busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t       exp_q  [N][$];
  logic [7:0] word_q [N][$];
  int         gap_q  [N][$];
  int         wait_n [N];
  int         words_sent [N];
  int         frames_seen [N];
  int         rb_err [N];
  int         base_hs [$];

  bit   mon_active [N];
  bit   mon_junk [N];
  int   mon_k [N];
  int   mon_err [N];
  exp_t mon_cur [N];
  bit   mon_have_h [N];
  int   mon_last_h [N];
  int   rb_notes = 0;

  uart_tx_stream #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(PE_P[0]),
                   .PARITY_ODD(PO_P[0]), .STOP_BITS(SB_P[0])) dut0 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .txd(txd_w[0]), .busy(busy[0]));

  uart_tx_stream #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(PE_P[1]),
                   .PARITY_ODD(PO_P[1]), .STOP_BITS(SB_P[1])) dut1 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .txd(txd_w[1]), .busy(busy[1]));

  uart_tx_stream #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(PE_P[2]),
                   .PARITY_ODD(PO_P[2]), .STOP_BITS(SB_P[2])) dut2 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .s_data(s_data[2]), .txd(txd_w[2]), .busy(busy[2]));

  uart_tx_stream #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(PE_P[3]),
                   .PARITY_ODD(PO_P[3]), .STOP_BITS(SB_P[3])) dut3 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
    .s_data(s_data[3]), .txd(txd_w[3]), .busy(busy[3]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- model
  function automatic int frame_len(input int i);
    return (1 + DW + PE_P[i] + SB_P[i]) * C;
  endfunction

  // Expected line level k cycles after the start bit begins.
  function automatic logic frame_level(input int i, input logic [7:0] d, input int k);
    int b;
    b = k / C;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (PE_P[i] != 0 && b == DW + 1) return 1'(($countones(d) + PO_P[i]) % 2);
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------- monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int i = 0; i < N; i++) begin
          mon_active[i] = 1'b0;
          mon_have_h[i] = 1'b0;
          exp_q[i].delete();
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          logic ready_exp, busy_exp, in_frame;
          in_frame  = mon_have_h[i] && (cyc > mon_last_h[i]);
          ready_exp = !(in_frame && cyc < mon_last_h[i] + frame_len(i));
          busy_exp  = in_frame && (cyc <= mon_last_h[i] + frame_len(i));
          if (s_ready[i] !== ready_exp || busy[i] !== busy_exp) begin
            rb_err[i]++;
            if (rb_notes < 8) begin
              rb_notes++;
              $display("note: inst %0d cycle %0d ready=%b/%b busy=%b/%b",
                       i, cyc, s_ready[i], ready_exp, busy[i], busy_exp);
            end
          end
          if (s_valid[i] && s_ready[i]) begin
            mon_have_h[i] = 1'b1;
            mon_last_h[i] = cyc;
          end

          if (mon_active[i]) begin
            if (!mon_junk[i] && txd_w[i] !== frame_level(i, mon_cur[i].data, mon_k[i]))
              mon_err[i]++;
            mon_k[i]++;
            if (mon_k[i] == frame_len(i)) begin
              mon_active[i] = 1'b0;
              if (!mon_junk[i]) begin
                check($sformatf("frame_i%0d_%02h", i, mon_cur[i].data), mon_err[i], 0);
                frames_seen[i]++;
              end
            end
          end else if (txd_w[i] === 1'b0) begin
            mon_active[i] = 1'b1;
            mon_k[i]      = 1;
            mon_err[i]    = 0;
            if (exp_q[i].size() == 0) begin
              mon_junk[i] = 1'b1;
              check($sformatf("unexpected_start_i%0d", i), 32'(exp_q[i].size()), 1);
            end else begin
              mon_junk[i] = 1'b0;
              mon_cur[i]  = exp_q[i].pop_front();
              check($sformatf("start_latency_i%0d", i), cyc, mon_cur[i].hs + 2);
            end
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic queue_word(input int i, input logic [7:0] d, input int gap);
    word_q[i].push_back(d);
    gap_q[i].push_back(gap);
  endtask

  task automatic queue_random(input int count);
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < count; w++) begin
        int g;
        g = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
        queue_word(i, 8'($urandom), g);
      end
    end
  endtask

  // One clock: observe handshakes at the negedge, update drives after posedge.
  task automatic step();
    bit hs [N];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      hs[i] = s_valid[i] && s_ready[i];
      if (hs[i]) begin
        exp_q[i].push_back('{data: s_data[i], hs: cyc});
        words_sent[i]++;
        if (i == 0) base_hs.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!(s_valid[i] && !hs[i])) begin
        if (word_q[i].size() > 0 && wait_n[i] >= gap_q[i][0]) begin
          s_valid[i] = 1'b1;
          s_data[i]  = word_q[i].pop_front();
          void'(gap_q[i].pop_front());
          wait_n[i]  = 0;
        end else begin
          if (word_q[i].size() > 0) wait_n[i]++;
          s_valid[i] = 1'b0;
          s_data[i]  = 8'($urandom);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      step();
      n++;
      pending = (s_valid != '0);
      for (int i = 0; i < N; i++) if (word_q[i].size() > 0) pending = 1'b1;
    end
    check("drain_within_budget", 32'(n < budget), 1);
    repeat (60) step();
    for (int i = 0; i < N; i++) begin
      check($sformatf("drained_busy_i%0d", i), 32'(busy[i]), 0);
      check($sformatf("drained_txd_i%0d", i), 32'(txd_w[i]), 1);
    end
  endtask

  // ----------------------------------------------------------------- main
  initial begin
    int idle_bad [N];
    int n0, guard;

    reset_n = 1'b1;
    s_valid = '0;
    for (int i = 0; i < N; i++) begin
      s_data[i] = '0;
      wait_n[i] = 0;
      idle_bad[i] = 0;
    end

    // Reset, then 100 idle cycles.
    #3 reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_txd_i%0d", i), 32'(txd_w[i]), 1);
      check($sformatf("reset_ready_i%0d", i), 32'(s_ready[i]), 1);
      check($sformatf("reset_busy_i%0d", i), 32'(busy[i]), 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (txd_w[i] !== 1'b1 || s_ready[i] !== 1'b1 || busy[i] !== 1'b0) idle_bad[i]++;
    end
    for (int i = 0; i < N; i++) check($sformatf("idle_hold_i%0d", i), idle_bad[i], 0);

    // Directed frames, then random traffic with random gaps.
    queue_word(0, 8'hA5, 0);
    queue_word(0, 8'h00, 5);
    queue_word(0, 8'hFF, 0);
    queue_word(1, 8'h07, 0);
    queue_word(2, 8'h07, 0);
    queue_word(3, 8'h3C, 0);
    queue_random(8);
    drain(4000);
    if (base_hs.size() >= 3)
      check("back_to_back_spacing", base_hs[2] - base_hs[1], frame_len(0));
    else
      check("back_to_back_handshakes", base_hs.size(), 3);

    // Reset during data bit 3 of 0x55.
    for (int i = 0; i < N; i++) queue_word(i, 8'h55, 0);
    n0 = base_hs.size();
    guard = 0;
    while (base_hs.size() == n0 && guard < 20) begin
      step();
      guard++;
    end
    check("abort_handshake_seen", 32'(base_hs.size() - n0), 1);
    repeat (18) @(negedge clk);
    check("abort_line_before", 32'(txd_w[0]), 0);
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("abort_txd_i%0d", i), 32'(txd_w[i]), 1);
      check($sformatf("abort_ready_i%0d", i), 32'(s_ready[i]), 1);
      check($sformatf("abort_busy_i%0d", i), 32'(busy[i]), 0);
      s_valid[i] = 1'b0;
      word_q[i].delete();
      gap_q[i].delete();
      wait_n[i] = 0;
      words_sent[i]--;
    end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Clean frame after the abort.
    for (int i = 0; i < N; i++) queue_word(i, 8'h81, 0);
    queue_random(4);
    drain(3000);

    for (int i = 0; i < N; i++) begin
      check($sformatf("frame_count_i%0d", i), frames_seen[i], words_sent[i]);
      check($sformatf("ready_busy_trace_i%0d", i), rb_err[i], 0);
      check($sformatf("scoreboard_empty_i%0d", i), 32'(exp_q[i].size()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
